exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have ports `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port `reset_n`, input, 1 bit: asynchronous, active-high reset (1 = reset asserted).
REQ-003 The block SHALL have ports `enable` in 1 (start request) and `data` in `control` struct: `i` (internal op: add, sub, and, or, xor, ld, st, incgamma, unsav), `op` 8 (MMIX opcode) and `xx` 8 (target register X).
REQ-004 The block SHALL have operand ports `y`, `z`, `b`, each input 64, with per-operand valid flags `y_valid`, `z_valid`, `b_valid`, each input 1.
REQ-005 The block SHALL have context inputs `G` 8 (first global register), `L` 8 (local count), and `O` and `S` 62 (register-stack offset and gamma).
REQ-006 The block SHALL have status outputs `done` 1 (completion pulse) and `interrupt` 19 (trip bits, valid with `done`).
REQ-007 The block SHALL have outputs `we_G` 1 and `new_G` 8 (rG update).
REQ-008 The block SHALL have outputs `gregwe`/`lregwe` 1, `gregwa`/`lregwa` 8 and `gregwd`/`lregwd` 64 (global/local register write ports).
REQ-009 The block SHALL have memory outputs `mem_address` 64, `mem_datasize` 2 (0 byte, 1 wyde, 2 tetra, 3 octa), `mem_read` 1, `mem_write` 1, `mem_writedata` 64.
REQ-010 The block SHALL have memory inputs `mem_readdata` 64 and `mem_done` 1.

Function
REQ-011 FSM states SHALL be IDLE, OPER, DONE.
REQ-012 In IDLE, `enable`=1 at a clock edge SHALL latch `data` and move to OPER; `enable` in OPER/DONE SHALL be ignored.
REQ-013 Required operands SHALL be: add/sub/and/or/xor/ld/unsav -> y,z; st/incgamma -> y,z,b.
REQ-014 Operands SHALL be read live (not latched) while valid; they are held stable by the source until `done`.
REQ-015 In OPER, ALU ops SHALL complete at the first edge where all required valids are 1, then go to DONE.
REQ-016 In OPER, memory ops SHALL assert `mem_read` (ld, unsav) or `mem_write` (st, incgamma) combinationally whenever all required valids are 1.
REQ-017 A memory access SHALL complete at the first edge where the request is asserted and `mem_done`=1, including the first request cycle; `mem_readdata` SHALL be captured at that edge and the FSM SHALL move to DONE.
REQ-018 `mem_done` without a request SHALL be ignored.
REQ-019 Address SHALL be (y+z) mod 2^64 with the low log2(size) bits cleared.
REQ-020 ld/st size SHALL be `op`[3:2]; incgamma/unsav SHALL use octa (3).
REQ-021 st/incgamma SHALL drive `mem_writedata`=b.
REQ-022 ld SHALL sign-extend the loaded value when `op`[1]=0 and zero-extend it when `op`[1]=1.
REQ-023 ALU results SHALL be y+z, y-z, y&z, y|z or y^z, mod 2^64.
REQ-024 add/sub signed overflow SHALL set `interrupt`[0]; all other interrupt bits SHALL be 0.
REQ-025 The register write for ALU/ld SHALL be selected by X=`xx`: if X>=G, `gregwe`=1, `gregwa`=X; else `lregwe`=1, `lregwa`=(O+X)[7:0]; write data = result.
REQ-026 unsav SHALL drive `we_G`=1, `new_G`=readdata[63:56]; if that value is <32, it SHALL set `interrupt`[1] and SHALL NOT assert `we_G`.
REQ-027 DONE SHALL last exactly 1 cycle: `done`=1 together with that op's write enables/`interrupt`, then return to IDLE.
REQ-028 Outside DONE, `done`, `we_G`, `gregwe`, `lregwe` and `interrupt` SHALL be 0.
REQ-029 `L`, `S` and `b` for non-store ops SHALL have no effect.

Reset
REQ-030 `reset_n`=1 SHALL immediately force IDLE and clear all outputs and registers to 0, aborting any in-flight access (requests drop).
REQ-031 The first accepted `enable` after reset release SHALL be handled normally.

Verification
REQ-032 incgamma: y=10 valid, then z=32, b=0x1234 valid a cycle later; `mem_done` after two request cycles -> `mem_write`=1, `mem_address`=40, `mem_datasize`=3, `mem_writedata`=0x1234 until `mem_done`; 1-cycle `done` follows.
REQ-033 unsav: xx=0, y=1, z=16 valid, `mem_done`=1 with readdata 0x200000000000FFFF on the first request cycle -> `mem_read`, address 16, octa; next cycle `done`=1, `we_G`=1, `new_G`=0x20.
REQ-034 add: y=0x7FFF_FFFF_FFFF_FFFF, z=1, xx=5, G=32, O=3 -> `lregwe`=1, `lregwa`=8, `lregwd`=0x8000_0000_0000_0000, `interrupt`[0]=1, with `done`.
REQ-035 ld LDB (op 0x80): y=0, z=3, xx=40, G=32, readdata byte 0x80 -> address 3, size 0, `gregwe`=1, `gregwa`=40, `gregwd`=0xFFFF_FFFF_FFFF_FF80.
REQ-036 Asserting reset mid-access -> `mem_read`/`mem_write` drop at once, no `done`; next op completes correctly.
REQ-037 unsav readdata 0x1000_0000_0000_0000 -> `interrupt`[1]=1, `we_G`=0.

Source files
------------

// File: rtl/exec_unit_if.sv
// exec_unit_if: request, operand, context, result and memory signals exchanged
// between an instruction dispatcher (master) and the execution unit (slave).
interface exec_unit_if;
   // i encodes the internal op: 0 add, 1 sub, 2 and, 3 or, 4 xor,
   // 5 ld, 6 st, 7 incgamma, 8 unsav.
   typedef struct packed {
      logic [3:0] i;
      logic [7:0] op;
      logic [7:0] xx;
   } control_t;

   logic        enable;
   control_t    data;
   logic [63:0] y, z, b;
   logic        y_valid, z_valid, b_valid;
   logic [7:0]  G, L;
   logic [61:0] O, S;

   logic        done;
   logic [18:0] interrupt;
   logic        we_G;
   logic [7:0]  new_G;
   logic        gregwe, lregwe;
   logic [7:0]  gregwa, lregwa;
   logic [63:0] gregwd, lregwd;

   logic [63:0] mem_address;
   logic [1:0]  mem_datasize;
   logic        mem_read, mem_write;
   logic [63:0] mem_writedata;
   logic [63:0] mem_readdata;
   logic        mem_done;

   modport master (
      output enable, data, y, z, b, y_valid, z_valid, b_valid, G, L, O, S,
             mem_readdata, mem_done,
      input  done, interrupt, we_G, new_G, gregwe, lregwe, gregwa, lregwa,
             gregwd, lregwd, mem_address, mem_datasize, mem_read, mem_write,
             mem_writedata
   );

   modport slave (
      input  enable, data, y, z, b, y_valid, z_valid, b_valid, G, L, O, S,
             mem_readdata, mem_done,
      output done, interrupt, we_G, new_G, gregwe, lregwe, gregwa, lregwa,
             gregwd, lregwd, mem_address, mem_datasize, mem_read, mem_write,
             mem_writedata
   );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: single-op execution unit (ALU ops, loads/stores, incgamma, unsav).
// Accepts one op in IDLE, waits in OPER for live operands (and memory), then
// reports results for exactly one cycle in DONE.
module exec_unit (
   input  logic        clk,
   input  logic        reset_n,
   exec_unit_if.slave  bus
);
   localparam logic [3:0] I_ADD   = 4'd0;
   localparam logic [3:0] I_SUB   = 4'd1;
   localparam logic [3:0] I_AND   = 4'd2;
   localparam logic [3:0] I_OR    = 4'd3;
   localparam logic [3:0] I_XOR   = 4'd4;
   localparam logic [3:0] I_LD    = 4'd5;
   localparam logic [3:0] I_ST    = 4'd6;
   localparam logic [3:0] I_INCG  = 4'd7;
   localparam logic [3:0] I_UNSAV = 4'd8;

   typedef enum logic [1:0] {IDLE = 2'd0, OPER = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q;
   logic [3:0]  iop_q;
   logic [7:0]  op_q, xx_q;
   logic        done_q, we_G_q, gregwe_q, lregwe_q;
   logic [18:0] irq_q;
   logic [7:0]  new_G_q, wa_q;
   logic [63:0] wd_q;

   logic               is_mem_d, is_wr_d, ops_ok_d, req_d, fire_d, ovf_d, gsel_d;
   logic [1:0]         size_d;
   logic [63:0]        sum_d, wd_d;
   logic signed [63:0] ys_d, zs_d, alu_d;
   logic [7:0]         lwa_d, newg_d;

   // Clear the low log2(size) address bits.
   function automatic logic [63:0] align_addr(input logic [63:0] a, input logic [1:0] sz);
      return a & ~((64'd1 << sz) - 64'd1);
   endfunction

   // Right-justified load data, sign- or zero-extended to 64 bits.
   function automatic logic [63:0] extend_load(input logic [63:0] rd, input logic [1:0] sz,
                                               input logic zext);
      logic [63:0] v;
      case (sz)
         2'd0:    v = {{56{rd[7]  & ~zext}}, rd[7:0]};
         2'd1:    v = {{48{rd[15] & ~zext}}, rd[15:0]};
         2'd2:    v = {{32{rd[31] & ~zext}}, rd[31:0]};
         default: v = rd;
      endcase
      return v;
   endfunction

   // Signed overflow: operand signs agree (add) or differ (sub) and the result sign flipped.
   function automatic logic add_sub_ovf(input logic signed [63:0] a, input logic signed [63:0] c,
                                        input logic signed [63:0] r, input logic sub);
      return ((a[63] ^ c[63]) == sub) && (r[63] != a[63]);
   endfunction

   // Operand readiness, memory request and next-result computation from live operands.
   always_comb begin
      is_mem_d = (iop_q == I_LD) || (iop_q == I_ST) || (iop_q == I_INCG) || (iop_q == I_UNSAV);
      is_wr_d  = (iop_q == I_ST) || (iop_q == I_INCG);
      size_d   = ((iop_q == I_LD) || (iop_q == I_ST)) ? op_q[3:2] : 2'd3;
      ops_ok_d = bus.y_valid && bus.z_valid && (bus.b_valid || !is_wr_d);
      req_d    = (state_q == OPER) && is_mem_d && ops_ok_d;
      fire_d   = (state_q == OPER) && ops_ok_d && (!is_mem_d || bus.mem_done);
      sum_d    = bus.y + bus.z;
      ys_d     = bus.y;
      zs_d     = bus.z;
      case (iop_q)
         I_ADD:   alu_d = ys_d + zs_d;
         I_SUB:   alu_d = ys_d - zs_d;
         I_AND:   alu_d = ys_d & zs_d;
         I_OR:    alu_d = ys_d | zs_d;
         I_XOR:   alu_d = ys_d ^ zs_d;
         default: alu_d = '0;
      endcase
      ovf_d  = ((iop_q == I_ADD) || (iop_q == I_SUB)) &&
               add_sub_ovf(ys_d, zs_d, alu_d, iop_q == I_SUB);
      wd_d   = (iop_q == I_LD) ? extend_load(bus.mem_readdata, op_q[3:2], op_q[1]) : alu_d;
      gsel_d = (xx_q >= bus.G);
      lwa_d  = bus.O[7:0] + xx_q;
      newg_d = bus.mem_readdata[63:56];
   end

   // Control FSM with registered result/strobe outputs; strobes live only in DONE.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q  <= IDLE;
         iop_q    <= '0;
         op_q     <= '0;
         xx_q     <= '0;
         done_q   <= 1'b0;
         we_G_q   <= 1'b0;
         gregwe_q <= 1'b0;
         lregwe_q <= 1'b0;
         irq_q    <= '0;
         new_G_q  <= '0;
         wa_q     <= '0;
         wd_q     <= '0;
      end else begin
         done_q   <= 1'b0;
         we_G_q   <= 1'b0;
         gregwe_q <= 1'b0;
         lregwe_q <= 1'b0;
         irq_q    <= '0;
         case (state_q)
            IDLE: begin
               if (bus.enable) begin
                  iop_q   <= bus.data.i;
                  op_q    <= bus.data.op;
                  xx_q    <= bus.data.xx;
                  state_q <= OPER;
               end
            end
            OPER: begin
               if (fire_d) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  if (iop_q == I_UNSAV) begin
                     new_G_q <= newg_d;
                     if (newg_d < 8'd32) irq_q[1] <= 1'b1;
                     else                we_G_q   <= 1'b1;
                  end else if (!is_wr_d) begin
                     irq_q[0] <= ovf_d;
                     wd_q     <= wd_d;
                     if (gsel_d) begin
                        gregwe_q <= 1'b1;
                        wa_q     <= xx_q;
                     end else begin
                        lregwe_q <= 1'b1;
                        wa_q     <= lwa_d;
                     end
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.done          = done_q;
   assign bus.interrupt     = irq_q;
   assign bus.we_G          = we_G_q;
   assign bus.new_G         = new_G_q;
   assign bus.gregwe        = gregwe_q;
   assign bus.lregwe        = lregwe_q;
   assign bus.gregwa        = wa_q;
   assign bus.lregwa        = wa_q;
   assign bus.gregwd        = wd_q;
   assign bus.lregwd        = wd_q;
   assign bus.mem_read      = req_d && !is_wr_d;
   assign bus.mem_write     = req_d && is_wr_d;
   assign bus.mem_address   = req_d ? align_addr(sum_d, size_d) : '0;
   assign bus.mem_datasize  = req_d ? size_d : 2'd0;
   assign bus.mem_writedata = (req_d && is_wr_d) ? bus.b : '0;

   // L, S, the upper O bits and unused opcode bits do not influence any result.
   logic unused_ctx;
   assign unused_ctx = ^{bus.L, bus.S, bus.O[61:8], op_q[7:4], op_q[0]};
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed and randomized ops against a behavioural model of exec_unit.
module tb_exec_unit;
   localparam logic [3:0] I_ADD   = 4'd0;
   localparam logic [3:0] I_SUB   = 4'd1;
   localparam logic [3:0] I_AND   = 4'd2;
   localparam logic [3:0] I_OR    = 4'd3;
   localparam logic [3:0] I_XOR   = 4'd4;
   localparam logic [3:0] I_LD    = 4'd5;
   localparam logic [3:0] I_ST    = 4'd6;
   localparam logic [3:0] I_INCG  = 4'd7;
   localparam logic [3:0] I_UNSAV = 4'd8;

   localparam logic signed [64:0] MAXS = 65'sh0_7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [64:0] MINS = 65'sh1_8000_0000_0000_0000;

   typedef struct packed {
      logic        mem;
      logic        wr;
      logic [63:0] addr;
      logic [1:0]  size;
      logic        gwe;
      logic        lwe;
      logic [7:0]  wa;
      logic [63:0] wd;
      logic        weg;
      logic [7:0]  newg;
      logic [18:0] irq;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   exec_unit_if bus ();
   exec_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: what the unit must do for one op, computed arithmetically.
   function automatic exp_t model(input logic [3:0] iop, input logic [7:0] op, input logic [7:0] xx,
                                  input logic [63:0] y, input logic [63:0] z,
                                  input logic [63:0] rd, input logic [7:0] g,
                                  input logic [61:0] o);
      exp_t              e;
      logic [63:0]       bytes, v, mask;
      logic signed [64:0] wide;
      int                nbits;
      e      = '0;
      e.mem  = (iop == I_LD) || (iop == I_ST) || (iop == I_INCG) || (iop == I_UNSAV);
      e.wr   = (iop == I_ST) || (iop == I_INCG);
      e.size = ((iop == I_LD) || (iop == I_ST)) ? op[3:2] : 2'd3;
      bytes  = 64'd1 << e.size;
      e.addr = ((y + z) / bytes) * bytes;
      wide   = '0;
      case (iop)
         I_ADD: begin e.wd = y + z; wide = $signed({y[63], y}) + $signed({z[63], z}); end
         I_SUB: begin e.wd = y - z; wide = $signed({y[63], y}) - $signed({z[63], z}); end
         I_AND: e.wd = y & z;
         I_OR:  e.wd = y | z;
         I_XOR: e.wd = y ^ z;
         I_LD: begin
            nbits = 8 << e.size;
            mask  = (nbits == 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
            v     = rd & mask;
            if (!op[1] && nbits < 64 && v[nbits-1]) v = v - (64'd1 << nbits);
            e.wd  = v;
         end
         default: e.wd = '0;
      endcase
      if ((iop == I_ADD || iop == I_SUB) && (wide > MAXS || wide < MINS)) e.irq[0] = 1'b1;
      if (iop <= I_LD) begin
         if (xx >= g) begin e.gwe = 1'b1; e.wa = xx; end
         else begin e.lwe = 1'b1; e.wa = 8'((o + 62'(xx)) % 62'd256); end
      end
      if (iop == I_UNSAV) begin
         e.newg = rd[63:56];
         if (rd[63:56] < 8'd32) e.irq[1] = 1'b1;
         else                   e.weg    = 1'b1;
      end
      return e;
   endfunction

   task automatic idle_inputs();
      bus.enable = 1'b0;  bus.data = '0;
      bus.y = '0; bus.z = '0; bus.b = '0;
      bus.y_valid = 1'b0; bus.z_valid = 1'b0; bus.b_valid = 1'b0;
      bus.G = '0; bus.L = '0; bus.O = '0; bus.S = '0;
      bus.mem_readdata = '0; bus.mem_done = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [3:0] iop, input logic [7:0] op,
                        input logic [7:0] xx, input logic [63:0] y, input logic [63:0] z,
                        input logic [63:0] b, input logic [63:0] rd, input logic [7:0] g,
                        input logic [61:0] o, input int vdelay, input int lat);
      exp_t e;
      e = model(iop, op, xx, y, z, rd, g, o);
      @(negedge clk);
      bus.data = {iop, op, xx}; bus.enable = 1'b1;
      bus.G = g; bus.O = o; bus.L = 8'($urandom); bus.S = 62'({$urandom, $urandom});
      bus.y = y; bus.z = z; bus.b = b; bus.mem_done = 1'b0;
      @(negedge clk);
      for (int k = 0; k < vdelay; k++) begin
         bus.y_valid = 1'b1;
         bus.enable = 1'b1; bus.data = 20'($urandom);
         bus.mem_done = 1'b1; bus.mem_readdata = {$urandom, $urandom};
         #1;
         chk({tag, "/noreq_rd"}, 64'(bus.mem_read), 64'd0);
         chk({tag, "/noreq_wr"}, 64'(bus.mem_write), 64'd0);
         @(negedge clk);
      end
      bus.enable = 1'b0;
      bus.y_valid = 1'b1; bus.z_valid = 1'b1; bus.b_valid = 1'b1;
      if (e.mem) begin
         for (int k = 0; k <= lat; k++) begin
            bus.mem_done = (k == lat);
            bus.mem_readdata = (k == lat) ? rd : {$urandom, $urandom};
            #1;
            chk({tag, "/mem_read"},  64'(bus.mem_read), 64'(!e.wr));
            chk({tag, "/mem_write"}, 64'(bus.mem_write), 64'(e.wr));
            chk({tag, "/addr"},      bus.mem_address, e.addr);
            chk({tag, "/size"},      64'(bus.mem_datasize), 64'(e.size));
            if (e.wr) chk({tag, "/wdata"}, bus.mem_writedata, b);
            chk({tag, "/early_done"}, 64'(bus.done), 64'd0);
            @(negedge clk);
         end
      end else begin
         #1;
         chk({tag, "/alu_noreq"}, 64'({bus.mem_read, bus.mem_write}), 64'd0);
         chk({tag, "/early_done"}, 64'(bus.done), 64'd0);
         @(negedge clk);
      end
      bus.y_valid = 1'b0; bus.z_valid = 1'b0; bus.b_valid = 1'b0;
      bus.mem_done = 1'b0; bus.mem_readdata = {$urandom, $urandom};
      #1;
      chk({tag, "/done"},   64'(bus.done), 64'd1);
      chk({tag, "/irq"},    64'(bus.interrupt), 64'(e.irq));
      chk({tag, "/we_G"},   64'(bus.we_G), 64'(e.weg));
      chk({tag, "/gregwe"}, 64'(bus.gregwe), 64'(e.gwe));
      chk({tag, "/lregwe"}, 64'(bus.lregwe), 64'(e.lwe));
      if (e.gwe) begin
         chk({tag, "/gregwa"}, 64'(bus.gregwa), 64'(e.wa));
         chk({tag, "/gregwd"}, bus.gregwd, e.wd);
      end
      if (e.lwe) begin
         chk({tag, "/lregwa"}, 64'(bus.lregwa), 64'(e.wa));
         chk({tag, "/lregwd"}, bus.lregwd, e.wd);
      end
      if (iop == I_UNSAV) chk({tag, "/new_G"}, 64'(bus.new_G), 64'(e.newg));
      @(negedge clk);
      #1;
      chk({tag, "/done_end"}, 64'({bus.done, bus.we_G, bus.gregwe, bus.lregwe}), 64'd0);
      chk({tag, "/irq_end"},  64'(bus.interrupt), 64'd0);
   endtask

   initial begin
      logic [3:0]  iop;
      logic [63:0] ry, rz, rrd;
      idle_inputs();
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset/done",   64'(bus.done), 64'd0);
      chk("reset/strobe", 64'({bus.we_G, bus.gregwe, bus.lregwe}), 64'd0);
      chk("reset/irq",    64'(bus.interrupt), 64'd0);
      chk("reset/req",    64'({bus.mem_read, bus.mem_write}), 64'd0);
      chk("reset/addr",   bus.mem_address, 64'd0);
      @(negedge clk);
      reset_n = 1'b0;

      do_op("incgamma", I_INCG, 8'h00, 8'd0, 64'd10, 64'd32, 64'h1234, 64'd0, 8'd32, 62'd0, 1, 2);
      do_op("unsav_ok", I_UNSAV, 8'h00, 8'd0, 64'd1, 64'd16, 64'd0,
            64'h2000_0000_0000_FFFF, 8'd32, 62'd0, 0, 0);
      do_op("add_ovf", I_ADD, 8'h20, 8'd5, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
            8'd32, 62'd3, 0, 0);
      do_op("ldb", I_LD, 8'h80, 8'd40, 64'd0, 64'd3, 64'd0, 64'h1234_5678_9ABC_DE80,
            8'd32, 62'd0, 0, 0);
      do_op("unsav_low", I_UNSAV, 8'h00, 8'd0, 64'd8, 64'd0, 64'd0,
            64'h1000_0000_0000_0000, 8'd32, 62'd0, 0, 1);
      do_op("ldwu", I_LD, 8'h86, 8'd32, 64'h100, 64'h7, 64'd0, 64'hFFFF_8001,
            8'd32, 62'd0, 0, 0);
      do_op("sub_ovf", I_SUB, 8'h24, 8'd1, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'd0,
            8'd200, 62'hFF, 2, 0);

      // Abort an in-flight load with reset, then run a normal op.
      @(negedge clk);
      bus.data = {I_LD, 8'h8C, 8'd40}; bus.enable = 1'b1;
      bus.y = 64'h1000; bus.z = 64'h8; bus.G = 8'd32;
      @(negedge clk);
      bus.enable = 1'b0; bus.y_valid = 1'b1; bus.z_valid = 1'b1;
      #1;
      chk("abort/req_before", 64'(bus.mem_read), 64'd1);
      #1 reset_n = 1'b1;
      #1;
      chk("abort/req_drop", 64'({bus.mem_read, bus.mem_write}), 64'd0);
      chk("abort/done",     64'(bus.done), 64'd0);
      @(negedge clk);
      reset_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      #1;
      chk("abort/no_done", 64'(bus.done), 64'd0);
      do_op("after_abort", I_LD, 8'h8C, 8'd40, 64'h1000, 64'h8, 64'd0,
            64'h0123_4567_89AB_CDEF, 8'd32, 62'd0, 0, 1);

      for (int n = 0; n < 40; n++) begin
         iop = 4'($urandom_range(0, 8));
         ry  = {$urandom, $urandom};
         rz  = {$urandom, $urandom};
         if (n % 5 == 0) begin ry = 64'h7FFF_FFFF_FFFF_FFF0 ^ 64'($urandom_range(0, 31)); end
         rrd = {$urandom, $urandom};
         do_op("rand", iop, 8'($urandom), 8'($urandom), ry, rz, {$urandom, $urandom}, rrd,
               8'($urandom), 62'({$urandom, $urandom}), $urandom_range(0, 2),
               $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
